// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard controller.
// Tag layout, ready-stage rule and the opcode classes decode uses to derive wr/ld/rt_st.
package fwd_pkg;

  localparam int RD_MAX_W = 8;
  localparam int SEL_RF   = 0;

  localparam logic [3:0] OP_LW         = 4'b1000;
  localparam logic [3:0] OP_SW         = 4'b1001;
  localparam logic [1:0] OP_CLASS_CTRL = 2'b11;

  typedef struct packed {
    logic                vld;
    logic [RD_MAX_W-1:0] rd;
    logic                wr;
    logic                ld;
    logic                st_fwd;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_BUBBLE = '0;

  // Stage index at which a producer's result can be forwarded.
  function automatic int ready_stage(input logic ld, input int load_lat);
    return ld ? (32'sd2 + load_lat) : 32'sd2;
  endfunction

  function automatic void decode_class(input logic [3:0] op, output logic wr,
                                       output logic ld, output logic rt_st);
    ld    = (op == OP_LW);
    rt_st = (op == OP_SW);
    wr    = !rt_st && (op[3:2] != OP_CLASS_CTRL);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Destination-tag shift register for the stages after ID.
// A bubble replaces the ID entry on stall/flush/invalid; flush also squashes the EX entry.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   bubble,
  input  logic                   flush,
  input  fwd_tag_t               id_tag,
  output fwd_tag_t [DEPTH:1]     tag
);

  fwd_tag_t [DEPTH:1] tag_r;

  // Tag shift on every pipeline advance; hold while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r <= '0;
    end else if (adv) begin
      tag_r[1] <= bubble ? TAG_BUBBLE : id_tag;
      tag_r[2] <= flush ? TAG_BUBBLE : tag_r[1];
      for (int k = 3; k <= DEPTH; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  assign tag = tag_r;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: registered EX selects, MEM-to-MEM store forward, ID stall.
// Optional FWD_PERF_CNT_EN adds saturating stall_cnt / fwd_cnt outputs.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter  int REG_W    = 4,
  parameter  int DEPTH    = 3,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_adv,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_rt_st,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_ld,
  output logic             stall_id,
  output logic [SEL_W-1:0] ex_sel_rs,
  output logic [SEL_W-1:0] ex_sel_rt,
  output logic             mem_st_fwd
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      fwd_cnt
`endif
);

  // A store can take load data in MEM only if the load is ready one stage past MEM.
  localparam logic ST_FWD_OK = (ready_stage(1'b1, LOAD_LAT) <= 32'sd3);

  fwd_tag_t [DEPTH:1] tag;
  fwd_tag_t           id_tag_s;
  logic               stall_s;
  logic               bubble_s;
  logic               rs_hz_s, rt_hz_s, rs_stf_s, rt_stf_s;
  logic [SEL_W-1:0]   rs_sel_s, rt_sel_s;
  logic               unused_s;

  // Youngest in-flight writer of src decides: forward, store-forward, or stall.
  function automatic void lookup(input fwd_tag_t [DEPTH:1] t, input logic [REG_W-1:0] src,
                                 input logic used, input logic st, output logic hz,
                                 output logic [SEL_W-1:0] sel, output logic stf);
    logic [SEL_W-1:0] yk;
    logic             y_ld;
    logic             hit;
    yk   = SEL_W'(SEL_RF);
    y_ld = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      hit  = used && (src != '0) && t[k].vld && t[k].wr && (t[k].rd == RD_MAX_W'(src));
      yk   = hit ? SEL_W'(k) : yk;
      y_ld = hit ? t[k].ld : y_ld;
    end
    hz  = 1'b0;
    sel = SEL_W'(SEL_RF);
    stf = 1'b0;
    if (yk == SEL_W'(SEL_RF)) begin
      sel = SEL_W'(SEL_RF);
    end else if (int'(yk) + 32'sd1 >= ready_stage(y_ld, LOAD_LAT)) begin
      sel = yk;
    end else if (st && y_ld && (yk == SEL_W'(1)) && ST_FWD_OK) begin
      stf = 1'b1;
    end else begin
      hz = 1'b1;
    end
  endfunction

  // Hazard detection and the tag offered to the EX stage.
  always_comb begin
    lookup(tag, id_rs, id_rs_used, 1'b0, rs_hz_s, rs_sel_s, rs_stf_s);
    lookup(tag, id_rt, id_rt_used, id_rt_st, rt_hz_s, rt_sel_s, rt_stf_s);
    stall_s  = id_valid && !flush && (rs_hz_s || rt_hz_s);
    bubble_s = stall_s || flush || !id_valid;
    id_tag_s = '{vld: 1'b1, rd: RD_MAX_W'(id_rd), wr: id_wr, ld: id_ld, st_fwd: rt_stf_s};
  end

  assign stall_id = stall_s;
  assign unused_s = ^{tag, rs_stf_s};

  fwd_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (pipe_adv),
    .bubble (bubble_s),
    .flush  (flush),
    .id_tag (id_tag_s),
    .tag    (tag)
  );

  // Selects follow the instruction entering EX; mem_st_fwd follows the entry entering MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sel_rs  <= SEL_W'(SEL_RF);
      ex_sel_rt  <= SEL_W'(SEL_RF);
      mem_st_fwd <= 1'b0;
    end else if (pipe_adv) begin
      ex_sel_rs  <= bubble_s ? SEL_W'(SEL_RF) : rs_sel_s;
      ex_sel_rt  <= bubble_s ? SEL_W'(SEL_RF) : rt_sel_s;
      mem_st_fwd <= !flush && tag[1].vld && tag[1].st_fwd;
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating event counters for stalls and registered forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      fwd_cnt   <= 16'd0;
    end else if (pipe_adv) begin
      if (stall_s && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (!bubble_s && ((rs_sel_s != '0) || (rt_sel_s != '0) || rt_stf_s) &&
          (fwd_cnt != 16'hFFFF)) begin
        fwd_cnt <= fwd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: two configurations (3/1 and 4/2) driven with shared stimulus,
// directed scenarios with fixed expectations plus randomized traffic against an instruction-list model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pipe_adv, flush, id_valid, id_rs_used, id_rt_used, id_rt_st, id_wr, id_ld;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       a_stall, b_stall, a_mst, b_mst;
  logic [1:0] a_sel_rs, a_sel_rt, b_sel_rs, b_sel_rt;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(4), .DEPTH(3), .LOAD_LAT(1)) dut_a (
`ifdef FWD_PERF_CNT_EN
    .stall_cnt(a_scnt), .fwd_cnt(a_fcnt),
`endif
    .clk(clk), .rst_n(rst_n), .pipe_adv(pipe_adv), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rt_st(id_rt_st), .id_rd(id_rd), .id_wr(id_wr), .id_ld(id_ld),
    .stall_id(a_stall), .ex_sel_rs(a_sel_rs), .ex_sel_rt(a_sel_rt), .mem_st_fwd(a_mst));

  fwd_hazard_ctrl #(.REG_W(4), .DEPTH(4), .LOAD_LAT(2)) dut_b (
`ifdef FWD_PERF_CNT_EN
    .stall_cnt(b_scnt), .fwd_cnt(b_fcnt),
`endif
    .clk(clk), .rst_n(rst_n), .pipe_adv(pipe_adv), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rt_st(id_rt_st), .id_rd(id_rd), .id_wr(id_wr), .id_ld(id_ld),
    .stall_id(b_stall), .ex_sel_rs(b_sel_rs), .ex_sel_rt(b_sel_rt), .mem_st_fwd(b_mst));

  // Reference model: list of instructions past ID, newest first (entry i is i+1 stages past ID).
  typedef struct { bit vld; bit [3:0] rd; bit wr; bit ld; bit stf; } rec_t;
  rec_t mq [2][8];
  int   exp_rs [2];
  int   exp_rt [2];
  bit   exp_mst [2];
  int   dep [2] = '{3, 4};
  int   lat [2] = '{1, 2};

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) mq[c][k] = '{vld: 0, rd: 0, wr: 0, ld: 0, stf: 0};
      exp_rs[c] = 0; exp_rt[c] = 0; exp_mst[c] = 0;
    end
  endfunction

  function automatic void src_eval(input int c, input bit [3:0] src, input bit used, input bit st,
                                   output bit hz, output int sel, output bit stf);
    int rdy;
    hz = 0; sel = 0; stf = 0;
    if (used && src != 0) begin
      for (int k = 1; k < dep[c]; k++) begin
        if (mq[c][k-1].vld && mq[c][k-1].wr && mq[c][k-1].rd == src) begin
          rdy = mq[c][k-1].ld ? 2 + lat[c] : 2;
          if (k + 1 >= rdy) sel = k;
          else if (st && mq[c][k-1].ld && k == 1 && rdy <= 3) stf = 1;
          else hz = 1;
          break;
        end
      end
    end
  endfunction

  function automatic bit model_stall(input int c);
    bit hs, ht, fs, ft; int ss, st;
    src_eval(c, id_rs, id_rs_used, 1'b0, hs, ss, fs);
    src_eval(c, id_rt, id_rt_used, id_rt_st, ht, st, ft);
    return id_valid && !flush && (hs || ht);
  endfunction

  function automatic void model_tick();
    bit hs, ht, fs, ft, stl, ins; int ss, st;
    for (int c = 0; c < 2; c++) begin
      if (pipe_adv) begin
        src_eval(c, id_rs, id_rs_used, 1'b0, hs, ss, fs);
        src_eval(c, id_rt, id_rt_used, id_rt_st, ht, st, ft);
        stl = id_valid && !flush && (hs || ht);
        ins = id_valid && !flush && !stl;
        exp_rs[c] = ins ? ss : 0;
        exp_rt[c] = ins ? st : 0;
        if (flush) mq[c][0].vld = 0;
        for (int k = 7; k >= 1; k--) mq[c][k] = mq[c][k-1];
        mq[c][0] = '{vld: ins, rd: id_rd, wr: id_wr, ld: id_ld, stf: ins && ft};
        exp_mst[c] = mq[c][1].vld && mq[c][1].stf;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                       input bit tst, input int rd, input bit wr, input bit ld);
    id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_rs_used = ru; id_rt_used = tu;
    id_rt_st = tst; id_rd = 4'(rd); id_wr = wr; id_ld = ld;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pipe_adv = 1; flush = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    pipe_adv = 1; flush = 0;
    drive(1, 1, 2, 1, 1, 0, 3, 1, 1);
    #1 rst_n = 0;
    #2;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", a_stall); end
    n_vec++; if ({a_sel_rs, a_sel_rt, a_mst} !== 5'b0) begin n_err++; $display("FAIL reset_a_outs: got %b want 0", {a_sel_rs, a_sel_rt, a_mst}); end
    n_vec++; if ({b_sel_rs, b_sel_rt, b_mst} !== 5'b0) begin n_err++; $display("FAIL reset_b_outs: got %b want 0", {b_sel_rs, b_sel_rt, b_mst}); end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #9 rst_n = 1;
    tick();
  endtask

  task automatic test_alu_fwd();
    drain();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0);
    tick();
    drive(1, 3, 3, 1, 1, 0, 4, 1, 0);
    #1;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL alu_no_stall: got %0b want 0", a_stall); end
    tick();
    n_vec++; if ({a_sel_rs, a_sel_rt} !== 4'b0101) begin n_err++; $display("FAIL alu_sel: got %b want 0101", {a_sel_rs, a_sel_rt}); end
    n_vec++; if (b_sel_rs !== 2'd1) begin n_err++; $display("FAIL alu_sel_b: got %0d want 1", b_sel_rs); end
  endtask

  task automatic test_load_use();
    drain();
    drive(1, 2, 0, 1, 0, 0, 5, 1, 1);
    tick();
    drive(1, 5, 1, 1, 1, 0, 6, 1, 0);
    #1;
    n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", a_stall); end
    tick();
    n_vec++; if (a_sel_rs !== 2'd0) begin n_err++; $display("FAIL lu_bubble_sel: got %0d want 0", a_sel_rs); end
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_end: got %0b want 0", a_stall); end
    tick();
    n_vec++; if ({a_sel_rs, a_sel_rt} !== 4'b1000) begin n_err++; $display("FAIL lu_sel: got %b want 1000", {a_sel_rs, a_sel_rt}); end
  endtask

  task automatic test_store_fwd();
    drain();
    drive(1, 2, 0, 1, 0, 0, 5, 1, 1);
    tick();
    drive(1, 2, 5, 1, 1, 1, 0, 0, 0);
    #1;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL st_no_stall: got %0b want 0", a_stall); end
    tick();
    n_vec++; if ({a_sel_rt, a_mst} !== 3'b000) begin n_err++; $display("FAIL st_ex: got %b want 000", {a_sel_rt, a_mst}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_vec++; if (a_mst !== 1'b1) begin n_err++; $display("FAIL st_mem_fwd: got %0b want 1", a_mst); end
  endtask

  task automatic test_priority();
    drain();
    drive(1, 1, 2, 1, 1, 0, 7, 1, 0);
    tick();
    tick();
    drive(1, 7, 0, 1, 1, 0, 8, 1, 0);
    tick();
    n_vec++; if ({a_sel_rs, a_sel_rt} !== 4'b0100) begin n_err++; $display("FAIL prio_sel: got %b want 0100", {a_sel_rs, a_sel_rt}); end
    drive(1, 1, 0, 1, 0, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 0, 9, 1, 0);
    #1;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL r0_no_stall: got %0b want 0", a_stall); end
    tick();
    n_vec++; if ({a_sel_rs, a_sel_rt} !== 4'b0000) begin n_err++; $display("FAIL r0_sel: got %b want 0000", {a_sel_rs, a_sel_rt}); end
  endtask

  task automatic test_lat2_freeze();
    drain();
    drive(1, 1, 0, 1, 0, 0, 2, 1, 1);
    tick();
    drive(1, 2, 2, 1, 1, 0, 3, 1, 0);
    #1;
    n_vec++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL l2_stall1: got %0b want 1", b_stall); end
    tick();
    n_vec++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL l2_stall2: got %0b want 1", b_stall); end
    pipe_adv = 0;
    tick();
    n_vec++; if ({b_stall, b_sel_rs} !== 3'b100) begin n_err++; $display("FAIL l2_freeze: got %b want 100", {b_stall, b_sel_rs}); end
    pipe_adv = 1;
    tick();
    n_vec++; if (b_stall !== 1'b0) begin n_err++; $display("FAIL l2_stall_end: got %0b want 0", b_stall); end
    tick();
    n_vec++; if ({b_sel_rs, b_sel_rt} !== 4'b1111) begin n_err++; $display("FAIL l2_sel: got %b want 1111", {b_sel_rs, b_sel_rt}); end
  endtask

  task automatic test_flush();
    drain();
    drive(1, 2, 0, 1, 0, 0, 5, 1, 1);
    tick();
    drive(1, 5, 1, 1, 1, 0, 6, 1, 0);
    #1;
    n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall: got %0b want 1", a_stall); end
    flush = 1;
    #1;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %0b want 0", a_stall); end
    tick();
    n_vec++; if (a_sel_rs !== 2'd0) begin n_err++; $display("FAIL fl_bubble: got %0d want 0", a_sel_rs); end
    flush = 0;
    #1;
    n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL fl_squashed_ld: got %0b want 0", a_stall); end
    tick();
  endtask

  task automatic test_reset_mid();
    drain();
    drive(1, 1, 2, 1, 1, 0, 3, 1, 0);
    tick();
    drive(1, 3, 0, 1, 0, 0, 5, 1, 1);
    tick();
    drive(1, 5, 5, 1, 1, 0, 6, 1, 0);
    #1;
    n_vec++; if ({a_stall, a_sel_rs} !== 3'b101) begin n_err++; $display("FAIL rm_pre: got %b want 101", {a_stall, a_sel_rs}); end
    rst_n = 0;
    #1;
    n_vec++; if ({a_stall, a_sel_rs, a_sel_rt, a_mst} !== 6'b0) begin n_err++; $display("FAIL rm_a: got %b want 0", {a_stall, a_sel_rs, a_sel_rt, a_mst}); end
    n_vec++; if ({b_stall, b_sel_rs, b_sel_rt, b_mst} !== 6'b0) begin n_err++; $display("FAIL rm_b: got %b want 0", {b_stall, b_sel_rs, b_sel_rt, b_mst}); end
    model_reset();
    #2 rst_n = 1;
    tick();
    n_vec++; if (a_sel_rs !== 2'd0) begin n_err++; $display("FAIL rm_after: got %0d want 0", a_sel_rs); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      pipe_adv = $urandom_range(0, 9) < 8;
      flush    = $urandom_range(0, 14) == 0;
      #1;
      n_vec++; if (a_stall !== model_stall(0)) begin n_err++; $display("FAIL rnd_a_stall @%0d: got %0b want %0b", i, a_stall, model_stall(0)); end
      n_vec++; if (b_stall !== model_stall(1)) begin n_err++; $display("FAIL rnd_b_stall @%0d: got %0b want %0b", i, b_stall, model_stall(1)); end
      tick();
      n_vec++; if (a_sel_rs !== 2'(exp_rs[0])) begin n_err++; $display("FAIL rnd_a_rs @%0d: got %0d want %0d", i, a_sel_rs, exp_rs[0]); end
      n_vec++; if (a_sel_rt !== 2'(exp_rt[0])) begin n_err++; $display("FAIL rnd_a_rt @%0d: got %0d want %0d", i, a_sel_rt, exp_rt[0]); end
      n_vec++; if (a_mst !== exp_mst[0]) begin n_err++; $display("FAIL rnd_a_mst @%0d: got %0b want %0b", i, a_mst, exp_mst[0]); end
      n_vec++; if (b_sel_rs !== 2'(exp_rs[1])) begin n_err++; $display("FAIL rnd_b_rs @%0d: got %0d want %0d", i, b_sel_rs, exp_rs[1]); end
      n_vec++; if (b_sel_rt !== 2'(exp_rt[1])) begin n_err++; $display("FAIL rnd_b_rt @%0d: got %0d want %0d", i, b_sel_rt, exp_rt[1]); end
      n_vec++; if (b_mst !== exp_mst[1]) begin n_err++; $display("FAIL rnd_b_mst @%0d: got %0b want %0b", i, b_mst, exp_mst[1]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_store_fwd();
    test_priority();
    test_lat2_freeze();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
